// File: rtl/misc_ctrl_if.sv
// Command, element-source and result-sink handshakes of the Misc job sequencer.
// slave = sequencer side, master = producer/consumer side.
interface misc_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [2:0]       cmd_fun_id;
    logic             cmd_asce;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_fun_id, cmd_asce, cmd_len,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_fun_id, cmd_asce, cmd_len,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/misc_ctrl.sv
// Job sequencer for the Misc unit: streams cmd_len elements into Misc and returns
// per-element nonlinear results or a serial dump of the k_sort slots.
//
// state   | meaning
// IDLE    | waiting for a command
// CLEAR   | one-cycle clear pulse to k_sort
// SORT    | accepting KSORT elements
// DRAIN   | SORT_LAT settle cycles before dumping
// DUMP    | presenting sorted slots 0..min(K,len)-1
// NL      | accepting NONLIN elements, streaming results
// DONE    | one cycle, then done pulse and back to IDLE
module misc_ctrl #(
    parameter int WIDTH    = 32,
    parameter int K        = 20,
    parameter int LEN_W    = 16,
    parameter int SORT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    misc_ctrl_if.slave           bus,
    output logic                 done,
    output logic [WIDTH-1:0]     m_in,
    output logic [WIDTH-1:0]     m_index,
    output logic [2:0]           m_fun_id,
    output logic                 m_asce,
    output logic                 m_clear_reg,
    output logic                 m_en,
    input  logic [WIDTH-1:0]     m_out_nonli,
    input  logic [K*WIDTH-1:0]   m_out_ksort
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SORT, S_DRAIN, S_DUMP, S_NL, S_DONE
    } state_t;

    localparam logic [7:0] DLY_INIT = 8'(SORT_LAT - 1);

    state_t           state, next_state;
    logic [LEN_W-1:0] len_q, cnt, slot_j, n_dump;
    logic [7:0]       dly;
    logic             nl_valid, skid_valid;
    logic [WIDTH-1:0] nl_data, skid_data, slot_data;
    logic             cmd_acc, in_acc, out_acc, last_in, nl_fin;

    assign cmd_acc = bus.cmd_valid & bus.cmd_ready;
    assign in_acc  = bus.in_valid & bus.in_ready;
    assign out_acc = bus.out_valid & bus.out_ready;
    assign last_in = (cnt == len_q - LEN_W'(1));
    assign n_dump  = (len_q > LEN_W'(K)) ? LEN_W'(K) : len_q;
    assign nl_fin  = (cnt == len_q) && !m_en && !skid_valid && (!nl_valid || bus.out_ready);

    always_comb begin
        slot_data = '0;
        for (int s = 0; s < K; s++) begin
            if (slot_j == LEN_W'(s)) slot_data = m_out_ksort[s*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cmd_acc) begin
                             if (bus.cmd_len == '0) next_state = S_DONE;
                             else if (bus.cmd_mode) next_state = S_CLEAR;
                             else                   next_state = S_NL;
                         end
                S_CLEAR: next_state = S_SORT;
                S_SORT:  if (in_acc && last_in) next_state = S_DRAIN;
                S_DRAIN: if (dly == '0) next_state = S_DUMP;
                S_DUMP:  if (out_acc && slot_j == n_dump - LEN_W'(1)) next_state = S_DONE;
                S_NL:    if (nl_fin) next_state = S_DONE;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE) && !abort;
        bus.in_ready  = 1'b0;
        if (!abort) begin
            if (state == S_SORT) bus.in_ready = 1'b1;
            if (state == S_NL)
                bus.in_ready = (cnt != len_q) && !skid_valid && (!nl_valid || bus.out_ready);
        end
        bus.out_valid = (state == S_DUMP) || nl_valid;
        bus.out_data  = (state == S_DUMP) ? slot_data : nl_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            m_in        <= '0;
            m_index     <= '0;
            m_fun_id    <= '0;
            m_asce      <= 1'b0;
            m_clear_reg <= 1'b0;
            m_en        <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            slot_j      <= '0;
            dly         <= '0;
            nl_valid    <= 1'b0;
            nl_data     <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
        end else begin
            done        <= (state == S_DONE) && !abort;
            m_clear_reg <= abort ? (state != S_IDLE) : (next_state == S_CLEAR);
            m_en        <= in_acc;

            if (cmd_acc) begin
                m_fun_id <= bus.cmd_fun_id;
                m_asce   <= bus.cmd_asce;
                len_q    <= bus.cmd_len;
                cnt      <= '0;
            end
            if (in_acc) begin
                m_in    <= bus.in_data;
                m_index <= WIDTH'(cnt);
                cnt     <= cnt + LEN_W'(1);
            end

            if (state != S_DRAIN) dly <= DLY_INIT;
            else if (dly != '0)   dly <= dly - 8'd1;

            if (state != S_DUMP) slot_j <= '0;
            else if (out_acc)    slot_j <= slot_j + LEN_W'(1);

            // The skid slot catches a result already in the Misc stage when the
            // output register stalls, keeping full throughput without loss.
            if (abort || state != S_NL) begin
                nl_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!nl_valid || bus.out_ready) begin
                if (skid_valid) begin
                    nl_data    <= skid_data;
                    nl_valid   <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (m_en) begin
                    nl_data  <= m_out_nonli;
                    nl_valid <= 1'b1;
                end else begin
                    nl_valid <= 1'b0;
                end
            end else if (m_en) begin
                skid_data  <= m_out_nonli;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_misc_ctrl.sv
// Scoreboard bench for misc_ctrl with a behavioural Misc model (nonlinear f = 3x+fun_id,
// k_sort = keep every element, present sorted order).
module tb_misc_ctrl;
    localparam int WIDTH = 32;
    localparam int K     = 20;
    localparam int LEN_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 abort = 1'b0;
    logic                 done;
    logic [WIDTH-1:0]     m_in, m_index;
    logic [2:0]           m_fun_id;
    logic                 m_asce, m_clear_reg, m_en;
    logic [WIDTH-1:0]     m_out_nonli;
    logic [K*WIDTH-1:0]   m_out_ksort = '0;

    misc_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus();

    misc_ctrl #(.WIDTH(WIDTH), .K(K), .LEN_W(LEN_W), .SORT_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus.slave), .done(done),
        .m_in(m_in), .m_index(m_index), .m_fun_id(m_fun_id), .m_asce(m_asce),
        .m_clear_reg(m_clear_reg), .m_en(m_en),
        .m_out_nonli(m_out_nonli), .m_out_ksort(m_out_ksort)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] out_q[$];
    int          lat_q[$];
    logic [31:0] din_q[$];
    int          idx_q[$];
    int          cur_fun = 0, done_exp = 0, done_seen = 0, done_cyc = 0, ordy_pct = 100;
    bit          cur_asce = 0, ks_job = 0, clr_seen = 0, chk_lat = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] ks_vals[$];
    logic [31:0] ks_tmp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string want);
        total++;
        bad++;
        $display("FAIL %s: got=%s want=%s", name, got, want);
    endtask

    // Misc model
    assign m_out_nonli = m_in * 32'd3 + {29'd0, m_fun_id};

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) ks_vals.delete();
        else begin
            if (m_clear_reg) ks_vals.delete();
            if (m_en) ks_vals.push_back(m_in);
        end
        ks_tmp = ks_vals;
        if (m_asce) ks_tmp.sort();
        else        ks_tmp.rsort();
        for (int j = 0; j < K; j++)
            m_out_ksort[j*WIDTH +: WIDTH] = (j < ks_tmp.size()) ? ks_tmp[j] : 32'd0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.out_ready = (int'($urandom_range(99)) < ordy_pct);
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) fail("unexpected_out", "beat", "none");
                else begin
                    logic [31:0] e;
                    int lt;
                    e  = out_q.pop_front();
                    lt = lat_q.pop_front();
                    chk("out_data", bus.out_data, e);
                    if (chk_lat) chk("latency", 64'(cyc - lt), 64'd2);
                end
            end
            if (prev_stall && bus.out_valid) chk("hold_data", bus.out_data, prev_data);
            if (bus.out_valid && !bus.out_ready && !ks_job) chk("in_ready_full", bus.in_ready, 0);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (m_en) begin
                if (din_q.size() == 0) fail("unexpected_strobe", "m_en", "none");
                else begin
                    chk("m_in", m_in, din_q.pop_front());
                    chk("m_index", m_index, 64'(idx_q.pop_front()));
                    chk("m_fun_id", m_fun_id, 64'(cur_fun));
                    if (ks_job) begin
                        chk("m_asce", m_asce, cur_asce);
                        chk("clear_before_strobe", clr_seen, 1);
                    end
                end
            end
            if (m_clear_reg) clr_seen = 1;
            if (done) begin
                if (done_exp == 0) fail("unexpected_done", "pulse", "none");
                else begin
                    done_exp--;
                    done_seen++;
                    done_cyc = cyc;
                end
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic issue_cmd(input bit mode, input int fun, input bit asce, input int len,
                             output int acc_cyc);
        int g = 0;
        bit acc = 0;
        cur_fun = fun; cur_asce = asce; ks_job = mode; clr_seen = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1; bus.cmd_mode = mode; bus.cmd_fun_id = 3'(fun);
        bus.cmd_asce = asce; bus.cmd_len = LEN_W'(len);
        acc_cyc = 0;
        while (!acc && g < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
            g++;
        end
        if (!acc) fail("cmd_timeout", "no accept", "accept");
        bus.cmd_valid = 0;
        // mid-job changes must have no effect
        bus.cmd_fun_id = 3'($urandom); bus.cmd_asce = 1'($urandom);
        bus.cmd_len = LEN_W'($urandom); bus.cmd_mode = 1'($urandom);
    endtask

    task automatic send_elems(input logic [31:0] d[$], input int gap, input bit nl, input int fun);
        for (int i = 0; i < d.size(); i++) begin
            int g = 0;
            bit acc = 0;
            if (int'($urandom_range(99)) < gap) begin
                bus.in_valid = 0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            bus.in_valid = 1;
            bus.in_data  = d[i];
            while (!acc && g < 200) begin
                @(negedge clk);
                acc = bus.in_ready;
                if (acc) begin
                    din_q.push_back(d[i]);
                    idx_q.push_back(i);
                    if (nl) begin
                        out_q.push_back(d[i] * 32'd3 + 32'(fun));
                        lat_q.push_back(cyc);
                    end
                end
                @(posedge clk); #1;
                g++;
            end
            if (!acc) fail("in_timeout", "no accept", "accept");
        end
        bus.in_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_seen < target && g < 3000) begin @(posedge clk); g++; end
        if (done_seen < target) fail("done_timeout", "no done", "done");
        @(posedge clk); #1;
    endtask

    task automatic run_job(input bit mode, input int fun, input bit asce, input logic [31:0] d[$],
                           input int gap, output int acc_cyc);
        logic [31:0] t[$];
        int target, n;
        target = done_seen + 1;
        done_exp++;
        if (mode) begin
            t = d;
            if (asce) t.sort(); else t.rsort();
            n = (t.size() > K) ? K : t.size();
            for (int i = 0; i < n; i++) begin out_q.push_back(t[i]); lat_q.push_back(0); end
        end
        issue_cmd(mode, fun, asce, d.size(), acc_cyc);
        send_elems(d, gap, !mode, fun);
        bus.in_valid = 1;
        bus.in_data  = 32'hdead_beef;
        repeat (3) begin
            @(negedge clk);
            chk("extra_beat_blocked", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        wait_done(target);
        chk("out_q_empty", 64'(out_q.size()), 0);
        chk("strobe_q_empty", 64'(din_q.size()), 0);
    endtask

    function automatic void rand_data(output logic [31:0] d[$], input int n, input int maxv);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(32'($urandom_range(maxv)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d[$];
        int ac, g;
        bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_fun_id = 0; bus.cmd_asce = 0;
        bus.cmd_len = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_clear", m_clear_reg, 0);

        // 1: NONLIN, full throughput, latency 2
        chk_lat = 1; ordy_pct = 100;
        d = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job(0, 2, 0, d, 0, ac);
        chk_lat = 0;

        // 2: NONLIN with 5-cycle sink stall
        rand_data(d, 3, 1000);
        fork
            run_job(0, 5, 0, d, 0, ac);
            begin
                g = 0;
                while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
                ordy_pct = 0;
                repeat (5) @(posedge clk);
                ordy_pct = 100;
            end
        join

        // 3: KSORT ascending, short
        ordy_pct = 70;
        d = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        run_job(1, 1, 1, d, 20, ac);

        // 4: KSORT longer than K
        rand_data(d, 30, 5000);
        run_job(1, 3, 0, d, 20, ac);

        // 5: zero-length command
        d.delete();
        run_job(0, 4, 0, d, 0, ac);
        chk("len0_done_latency", 64'(done_cyc - ac), 64'd2);

        // 6: abort during SORT after 2 elements
        rand_data(d, 2, 500);
        issue_cmd(1, 6, 1, 6, ac);
        send_elems(d, 0, 0, 6);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_clear_pulse", m_clear_reg, 1);
        chk("abort_idle", bus.cmd_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_strobe_q_empty", 64'(din_q.size()), 0);
        rand_data(d, 7, 100000);
        run_job(0, 7, 0, d, 30, ac);

        // 7: reset during DUMP
        ordy_pct = 0;
        d = '{32'd40, 32'd10, 32'd30, 32'd20, 32'd50};
        issue_cmd(1, 0, 1, 5, ac);
        send_elems(d, 0, 0, 0);
        g = 0;
        while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
        chk("dump_reached", bus.out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_m_en", m_en, 0);
        chk("rst_mid_m_in", m_in, 0);
        chk("rst_mid_m_index", m_index, 0);
        chk("rst_mid_done", done, 0);
        out_q.delete(); lat_q.delete(); din_q.delete(); idx_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        // random jobs
        ordy_pct = 60;
        for (int n = 0; n < 6; n++) begin
            bit md;
            md = 1'($urandom);
            rand_data(d, int'($urandom_range(1, 25)), 1 << 20);
            run_job(md, int'($urandom_range(7)), 1'($urandom), d, 30, ac);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
